// File: rtl/reg_wb_ctrl.sv
// Register-file writeback arbiter: merges ALU results and buffered load returns onto
// the single write port, and keeps a per-register load-pending scoreboard for issue stall.
module reg_wb_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [2:0]                    alu_rd,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          ld_issue,
  input  logic [2:0]                    ld_rd,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [2:0]                    mem_rd,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  input  logic [2:0]                    chk_rs1,
  input  logic [2:0]                    chk_rs2,
  input  logic [2:0]                    chk_rd,
  output logic                          stall,
  output logic                          wr_en,
  output logic [2:0]                    wr_rd,
  output logic [DATA_WIDTH-1:0]         wr_din,
  output logic [7:0]                    busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [FIFO_DEPTH-1:0][2:0]            rd_mem_q;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] dat_mem_q;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d, from_fifo_q, from_fifo_d;
  logic [2:0]            wr_rd_q, wr_rd_d;
  logic [DATA_WIDTH-1:0] wr_din_q, wr_din_d;
  logic [7:0]            busy_q, busy_d;
  logic                  push, pop;

  assign mem_ready = rst_n && (cnt_q < CW'(FIFO_DEPTH));
  assign push      = mem_valid && mem_ready;
  assign pop       = !alu_valid && (cnt_q != '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q + CW'(push) - CW'(pop);
    wr_en_d     = 1'b0;
    wr_rd_d     = wr_rd_q;
    wr_din_d    = wr_din_q;
    from_fifo_d = 1'b0;
    busy_d      = busy_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    // ALU always wins the port; a queued load waits until an ALU-free cycle.
    if (alu_valid) begin
      wr_en_d  = (alu_rd != 3'd0);
      wr_rd_d  = alu_rd;
      wr_din_d = alu_data;
    end else if (pop) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      wr_en_d     = (rd_mem_q[rd_ptr_q] != 3'd0);
      wr_rd_d     = rd_mem_q[rd_ptr_q];
      wr_din_d    = dat_mem_q[rd_ptr_q];
      from_fifo_d = 1'b1;
    end
    // Clear on the commit edge of a load write so dependents only read the new value.
    if (wr_en_q && from_fifo_q) busy_d[wr_rd_q] = 1'b0;
    if (ld_issue && ld_rd != 3'd0) busy_d[ld_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_rd_q     <= '0;
      wr_din_q    <= '0;
      from_fifo_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      wr_rd_q     <= wr_rd_d;
      wr_din_q    <= wr_din_d;
      from_fifo_q <= from_fifo_d;
      busy_q      <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]  <= mem_rd;
      dat_mem_q[wr_ptr_q] <= mem_data;
    end
  end

  assign stall    = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
  assign wr_en    = wr_en_q;
  assign wr_rd    = wr_rd_q;
  assign wr_din   = wr_din_q;
  assign busy     = busy_q;
  assign fifo_cnt = cnt_q;
endmodule
